// File: rtl/i2c_banked_ram_ctrl.sv
// Two-bank (LOCAL/REMOTE) word RAM for the I2C LCD menu design with a sequential
// clear engine, menu-port stall while clearing and registered read-valid strobes.
module i2c_banked_ram_ctrl #(
   parameter int                DATA_W    = 8,
   parameter int                ADDR_W    = 5,
   parameter logic [DATA_W-1:0] CLEAR_VAL = 8'h20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mp_sel,
   input  logic [ADDR_W-1:0] mp_addr,
   input  logic [DATA_W-1:0] mp_din,
   input  logic              mp_we,
   input  logic              mp_re,
   output logic              mp_ready,
   output logic [DATA_W-1:0] mp_dout,
   output logic              mp_dvalid,
   input  logic [ADDR_W-1:0] rw_addr,
   input  logic [DATA_W-1:0] rw_din,
   input  logic              rw_we,
   input  logic [ADDR_W-1:0] lr_addr,
   input  logic              lr_re,
   output logic [DATA_W-1:0] lr_dout,
   output logic              lr_dvalid,
   input  logic              clr_req,
   input  logic              clr_sel,
   output logic              clr_busy,
   output logic              clr_done
);

   localparam int                DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST  = '1;

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;
   logic              bank, bank_nxt;
   logic              done_nxt;
   logic              clr_wr_local, clr_wr_remote;
   logic              mp_wr_local, mp_rd;

   logic [DATA_W-1:0] local_mem  [DEPTH];
   logic [DATA_W-1:0] remote_mem [DEPTH];

   assign clr_busy    = (state != S_IDLE);
   assign mp_ready    = ~clr_busy;
   assign mp_wr_local = mp_ready & mp_we & ~mp_sel;
   assign mp_rd       = mp_ready & mp_re;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         bank     <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         bank     <= bank_nxt;
         clr_done <= done_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      bank_nxt      = bank;
      done_nxt      = 1'b0;
      clr_wr_local  = 1'b0;
      clr_wr_remote = 1'b0;
      case (state)
         S_IDLE: begin
            if (clr_req) begin
               bank_nxt  = clr_sel;
               cnt_nxt   = '0;
               state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: begin
            // An I2C receive write owns the REMOTE port; the clear retries the same address.
            if (!(bank && rw_we)) begin
               clr_wr_local  = ~bank;
               clr_wr_remote = bank;
               if (cnt == LAST) state_nxt = S_DONE;
               else             cnt_nxt   = cnt + 1'b1;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mp_wr_local)       local_mem[mp_addr] <= mp_din;
      else if (clr_wr_local) local_mem[cnt]     <= CLEAR_VAL;
      if (rw_we)              remote_mem[rw_addr] <= rw_din;
      else if (clr_wr_remote) remote_mem[cnt]     <= CLEAR_VAL;
   end

   // Reads sample the arrays before this edge's writes land (read-first).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mp_dout   <= '0;
         mp_dvalid <= 1'b0;
         lr_dout   <= '0;
         lr_dvalid <= 1'b0;
      end else begin
         mp_dvalid <= mp_rd;
         lr_dvalid <= lr_re;
         if (mp_rd) mp_dout <= mp_sel ? remote_mem[mp_addr] : local_mem[mp_addr];
         if (lr_re) lr_dout <= local_mem[lr_addr];
      end
   end

endmodule

// File: tb/tb_i2c_banked_ram_ctrl.sv
// Randomized and directed bench for i2c_banked_ram_ctrl against a queue-based
// behavioural model of the two banks and the clear process.
module tb_i2c_banked_ram_ctrl;
   localparam int         DATA_W = 8;
   localparam int         ADDR_W = 5;
   localparam int         DEPTH  = 32;
   localparam logic [7:0] CV     = 8'h20;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              mp_sel, mp_we, mp_re, rw_we, lr_re, clr_req, clr_sel;
   logic [ADDR_W-1:0] mp_addr, rw_addr, lr_addr;
   logic [DATA_W-1:0] mp_din, rw_din;
   logic              mp_ready, mp_dvalid, lr_dvalid, clr_busy, clr_done;
   logic [DATA_W-1:0] mp_dout, lr_dout;

   always #5 clk = ~clk;

   i2c_banked_ram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLEAR_VAL(CV)) dut (
      .clk(clk), .rst(rst),
      .mp_sel(mp_sel), .mp_addr(mp_addr), .mp_din(mp_din), .mp_we(mp_we), .mp_re(mp_re),
      .mp_ready(mp_ready), .mp_dout(mp_dout), .mp_dvalid(mp_dvalid),
      .rw_addr(rw_addr), .rw_din(rw_din), .rw_we(rw_we),
      .lr_addr(lr_addr), .lr_re(lr_re), .lr_dout(lr_dout), .lr_dvalid(lr_dvalid),
      .clr_req(clr_req), .clr_sel(clr_sel), .clr_busy(clr_busy), .clr_done(clr_done)
   );

   // Reference model: bank contents, pending clear addresses, and a one-cycle done tail.
   logic [7:0] ref_local  [DEPTH];
   logic [7:0] ref_remote [DEPTH];
   int         pend[$];
   bit         m_tail, m_bank;
   logic [7:0] e_mp_dout, e_lr_dout;
   bit         e_mp_dv, e_lr_dv, e_done;
   int         n_vec, n_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit m_busy();
      return (pend.size() > 0) || m_tail;
   endfunction

   task automatic model_reset();
      pend.delete();
      m_tail    = 1'b0;
      e_done    = 1'b0;
      e_mp_dv   = 1'b0;
      e_lr_dv   = 1'b0;
      e_mp_dout = '0;
      e_lr_dout = '0;
   endtask

   task automatic idle_inputs();
      mp_sel = 0; mp_addr = '0; mp_din = '0; mp_we = 0; mp_re = 0;
      rw_addr = '0; rw_din = '0; rw_we = 0; lr_addr = '0; lr_re = 0;
      clr_req = 0; clr_sel = 0;
   endtask

   // Predict the effect of the coming rising edge from the inputs now applied.
   task automatic model_edge();
      bit busy;
      int a;
      if (rst) begin
         model_reset();
         return;
      end
      busy    = m_busy();
      e_mp_dv = mp_re && !busy;
      if (e_mp_dv) e_mp_dout = mp_sel ? ref_remote[mp_addr] : ref_local[mp_addr];
      e_lr_dv = lr_re;
      if (lr_re) e_lr_dout = ref_local[lr_addr];
      if (mp_we && !busy && !mp_sel) ref_local[mp_addr] = mp_din;
      if (rw_we) ref_remote[rw_addr] = rw_din;
      e_done = 1'b0;
      if (pend.size() > 0) begin
         if (!(m_bank && rw_we)) begin
            a = pend.pop_front();
            if (m_bank) ref_remote[a] = CV;
            else        ref_local[a]  = CV;
            if (pend.size() == 0) m_tail = 1'b1;
         end
      end else if (m_tail) begin
         m_tail = 1'b0;
         e_done = 1'b1;
      end else if (clr_req) begin
         m_bank = clr_sel;
         for (int i = 0; i < DEPTH; i++) pend.push_back(i);
      end
   endtask

   task automatic compare_all();
      check("mp_ready", mp_ready, !m_busy());
      check("clr_busy", clr_busy, m_busy());
      check("clr_done", clr_done, e_done);
      check("mp_dvalid", mp_dvalid, e_mp_dv);
      check("lr_dvalid", lr_dvalid, e_lr_dv);
      check("mp_dout", mp_dout, e_mp_dout);
      check("lr_dout", lr_dout, e_lr_dout);
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic read_lr(input int a, output logic [7:0] d);
      lr_re = 1; lr_addr = a[ADDR_W-1:0];
      tick();
      lr_re = 0;
      d = lr_dout;
   endtask

   task automatic read_remote(input int a, output logic [7:0] d);
      mp_re = 1; mp_sel = 1; mp_addr = a[ADDR_W-1:0];
      tick();
      mp_re = 0; mp_sel = 0;
      d = mp_dout;
   endtask

   task automatic fill_local();
      for (int i = 0; i < DEPTH; i++) begin
         mp_we = 1; mp_sel = 0; mp_addr = i[ADDR_W-1:0]; mp_din = i[7:0];
         tick();
      end
      idle_inputs();
   endtask

   // Issue a clear; optionally inject an rw write at a given edge after the request.
   task automatic run_clear(input bit sel, input int stall_edge, input int stall_addr,
                            input logic [7:0] stall_din, output int edges, output int busy_cyc);
      clr_req = 1; clr_sel = sel;
      tick();
      clr_req = 0; clr_sel = 0;
      busy_cyc = clr_busy ? 1 : 0;
      edges = 0;
      for (int k = 1; k <= 100; k++) begin
         if (k == stall_edge) begin
            rw_we = 1; rw_addr = stall_addr[ADDR_W-1:0]; rw_din = stall_din;
         end
         if (k == 10) begin
            mp_we = 1; mp_sel = 0; mp_addr = 5'd2; mp_din = 8'h55; mp_re = 1;
         end
         if (k == 5) begin
            clr_req = 1; clr_sel = ~sel;
         end
         tick();
         if (k == 10) check("drop_mp_dvalid", mp_dvalid, 1'b0);
         idle_inputs();
         if (clr_busy) busy_cyc++;
         edges = k;
         if (clr_done) break;
      end
   endtask

   initial begin
      logic [7:0] d;
      int edges, busy_cyc;
      n_vec = 0; n_err = 0;
      idle_inputs();
      model_reset();
      m_bank = 0;
      #12;
      check("rst_mp_ready", mp_ready, 1'b1);
      check("rst_clr_busy", clr_busy, 1'b0);
      check("rst_clr_done", clr_done, 1'b0);
      check("rst_mp_dout", mp_dout, 8'h00);
      check("rst_lr_dout", lr_dout, 8'h00);
      check("rst_dvalids", {mp_dvalid, lr_dvalid}, 2'b00);
      rst = 0;

      // Known contents: LOCAL[i] = i, REMOTE[i] = ~i.
      for (int i = 0; i < DEPTH; i++) begin
         mp_we = 1; mp_sel = 0; mp_addr = i[ADDR_W-1:0]; mp_din = i[7:0];
         rw_we = 1; rw_addr = i[ADDR_W-1:0]; rw_din = ~i[7:0];
         tick();
      end
      idle_inputs();

      mp_we = 1; mp_addr = 5'd5; mp_din = 8'hA5;
      tick();
      idle_inputs();
      mp_re = 1; mp_addr = 5'd5; lr_re = 1; lr_addr = 5'd5;
      tick();
      idle_inputs();
      check("rd5_mp", {mp_dvalid, mp_dout}, {1'b1, 8'hA5});
      check("rd5_lr", {lr_dvalid, lr_dout}, {1'b1, 8'hA5});
      tick();
      check("rd5_pulse", {mp_dvalid, lr_dvalid}, 2'b00);

      mp_we = 1; mp_addr = 5'd7; mp_din = 8'h3C; lr_re = 1; lr_addr = 5'd7;
      tick();
      idle_inputs();
      check("rd_first", lr_dout, 8'h07);
      read_lr(7, d);
      check("rd_after_wr", d, 8'h3C);
      mp_we = 1; mp_sel = 1; mp_addr = 5'd9; mp_din = 8'hFF;
      tick();
      idle_inputs();
      read_remote(9, d);
      check("remote_unchanged", d, 8'hF6);

      run_clear(1'b0, 0, 0, 8'h00, edges, busy_cyc);
      check("lclr_done_edge", edges, 33);
      check("lclr_busy_cycles", busy_cyc, 33);
      tick();
      check("lclr_single_done", clr_done, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         read_lr(i, d);
         check("lclr_word", d, CV);
      end

      run_clear(1'b1, 4, 3, 8'h11, edges, busy_cyc);
      check("rclr3_done_edge", edges, 34);
      read_remote(3, d);
      check("rclr3_word", d, CV);
      run_clear(1'b1, 11, 20, 8'h11, edges, busy_cyc);
      check("rclr20_done_edge", edges, 34);
      read_remote(20, d);
      check("rclr20_word", d, CV);

      fill_local();
      clr_req = 1; clr_sel = 0;
      tick();
      idle_inputs();
      for (int k = 0; k < 12; k++) tick();
      rst = 1;
      #1;
      model_reset();
      check("abort_busy", clr_busy, 1'b0);
      check("abort_ready", mp_ready, 1'b1);
      check("abort_done", clr_done, 1'b0);
      tick();
      rst = 0;
      for (int k = 0; k < 3; k++) tick();
      for (int i = 0; i < DEPTH; i++) begin
         read_lr(i, d);
         check("abort_word", d, (i < 12) ? CV : i[7:0]);
      end

      // Randomized traffic, every cycle checked against the model.
      for (int n = 0; n < 1500; n++) begin
         mp_sel  = 1'($urandom_range(0, 1));
         mp_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
         mp_din  = 8'($urandom);
         mp_we   = ($urandom_range(0, 2) == 0);
         mp_re   = ($urandom_range(0, 1) == 0);
         rw_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
         rw_din  = 8'($urandom);
         rw_we   = ($urandom_range(0, 3) == 0);
         lr_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
         lr_re   = ($urandom_range(0, 1) == 0);
         clr_req = ($urandom_range(0, 49) == 0);
         clr_sel = 1'($urandom_range(0, 1));
         tick();
      end
      idle_inputs();
      for (int k = 0; k < 100 && m_busy(); k++) tick();
      check("final_idle", clr_busy, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         read_lr(i, d);
         read_remote(i, d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
